// File: rtl/prog_cntr.sv
// Programmable counter: prescaled tick, up/down/bounce modes, modulo wrap,
// parallel load, terminal-count pulse and a count snapshot register.
module prog_cntr #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 4,
  parameter int unsigned RESET_VAL  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      modulo,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  snap,
  output logic [WIDTH-1:0]      qout,
  output logic [WIDTH-1:0]      snap_q,
  output logic                  tc,
  output logic                  dir
);

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  localparam logic [WIDTH-1:0] CNT_RST = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]      snap_val_q, snap_val_d;
  logic                  tc_q, tc_d;
  logic                  dir_q, dir_d;
  logic [PRESCALE_W-1:0] pc_q, pc_d;
  logic                  active;
  logic                  tick;

  // ">=" rather than "==" so a prescale lowered below pc ticks immediately.
  assign active = en && (mode != MODE_HOLD);
  assign tick   = active && (pc_q >= prescale);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (an unassigned path in always_comb infers a latch).
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    pc_d       = pc_q;
    tc_d       = 1'b0;
    snap_val_d = snap ? cnt_q : snap_val_q;

    if (load) begin
      cnt_d = (load_val <= modulo) ? load_val : modulo;
      pc_d  = '0;
    end else if (active) begin
      pc_d = tick ? '0 : pc_q + 1'b1;
      if (tick) begin
        case (mode)
          MODE_UP: begin
            if (cnt_q >= modulo) begin
              cnt_d = '0;
              tc_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + ONE;
            end
          end
          MODE_DOWN: begin
            if (cnt_q == '0) begin
              cnt_d = modulo;
              tc_d  = 1'b1;
            end else if (cnt_q > modulo) begin
              cnt_d = modulo;
            end else begin
              cnt_d = cnt_q - ONE;
            end
          end
          MODE_BOUNCE: begin
            // A zero-length range cannot move; it only turns around.
            if (modulo == '0) begin
              cnt_d = '0;
              tc_d  = 1'b1;
              dir_d = ~dir_q;
            end else if (!dir_q) begin
              if (cnt_q >= modulo) begin
                cnt_d = modulo - ONE;
                dir_d = 1'b1;
                tc_d  = 1'b1;
              end else begin
                cnt_d = cnt_q + ONE;
              end
            end else begin
              if (cnt_q == '0) begin
                cnt_d = ONE;
                dir_d = 1'b0;
                tc_d  = 1'b1;
              end else if (cnt_q > modulo) begin
                cnt_d = modulo;
              end else begin
                cnt_d = cnt_q - ONE;
              end
            end
          end
          default: cnt_d = cnt_q;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= CNT_RST;
      snap_val_q <= '0;
      tc_q       <= 1'b0;
      dir_q      <= 1'b0;
      pc_q       <= '0;
    end else begin
      cnt_q      <= cnt_d;
      snap_val_q <= snap_val_d;
      tc_q       <= tc_d;
      dir_q      <= dir_d;
      pc_q       <= pc_d;
    end
  end

  assign qout   = cnt_q;
  assign snap_q = snap_val_q;
  assign tc     = tc_q;
  assign dir    = dir_q;

endmodule

// File: doc/prog_cntr.md
Name: prog_cntr

Overview:
Parametrised, programmable counter that generalises the fixed 8-bit LED counter used in the readback-capture demo designs.
- Adds configurable width, prescaled tick rate, up/down/bounce modes, programmable modulo, parallel load, terminal-count pulse and a snapshot register.
- The snapshot register lets readback captures be correlated with a known count value.
- Sits between the BSCANE2-controlled clock domain and the LED/status outputs.

Parameters:
WIDTH, 8, counter and load/modulo width (2..32)
PRESCALE_W, 4, width of prescaler compare value
RESET_VAL, 0, value of qout after reset (must be <= 2^WIDTH-1)

Ports:
clk  in  1  single clock, all logic rising-edge
reset  in  1  synchronous, active-high reset
en  in  1  count enable; gates prescaler and ticks
mode  in  2  00 up, 01 down, 10 bounce (up/down ping-pong), 11 hold
load  in  1  parallel load strobe
load_val  in  WIDTH  value loaded on load
modulo  in  WIDTH  maximum count; range is 0..modulo
prescale  in  PRESCALE_W  tick every prescale+1 enabled cycles
snap  in  1  snapshot strobe
qout  out  WIDTH  current count (registered)
snap_q  out  WIDTH  captured count (registered)
tc  out  1  terminal-count pulse, one cycle per wrap/turn
dir  out  1  bounce direction, 0 up / 1 down (registered)

Behaviour:
- Reset (sync, high): qout=RESET_VAL, snap_q=0, tc=0, dir=0, prescaler count pc=0. Reset has highest priority.
- Priority per cycle: reset > load > tick > hold.
- Prescaler:
  - pc advances only when en=1 and mode!=11.
  - tick=1 when pc==prescale; pc then returns to 0, otherwise pc+1.
  - prescale=0 gives a tick every enabled cycle.
  - A prescale change takes effect on the next compare. If pc>prescale, the next enabled cycle forces tick and pc=0.
- Load (ignores en and mode):
  - qout <= load_val if load_val<=modulo, else qout <= modulo.
  - pc <= 0, tc <= 0, dir unchanged.
- Tick, mode 00 (up): qout>=modulo -> qout<=0, tc<=1. Else qout+1.
- Tick, mode 01 (down): qout==0 -> qout<=modulo, tc<=1. qout>modulo -> qout<=modulo, no tc. Else qout-1.
- Tick, mode 10 (bounce):
  - dir=0: qout>=modulo -> dir<=1, qout<=modulo-1, tc<=1. Else qout+1.
  - dir=1: qout==0 -> dir<=0, qout<=1, tc<=1. qout>modulo -> qout<=modulo, no tc. Else qout-1.
  - modulo==0: qout stays 0, tc<=1 every tick, dir toggles.
  - modulo==1 turnaround: qout<=0 (dir=0→1) or qout<=1 (dir=1→0), tc<=1.
- Mode 11, or en=0: qout, dir and pc hold; tc<=0.
- dir is only updated in mode 10; in modes 00/01 it holds its value. A mode change takes effect on the next tick.
- tc: registered, high for exactly one cycle, coincident with qout showing the wrapped/turned value. Otherwise 0.
- Snapshot: snap=1 -> snap_q <= qout value present in that cycle, i.e. the pre-update value, even with simultaneous load or tick. snap is independent of en and mode. A snap during reset is ignored (snap_q=0).
- No combinational path from inputs to outputs. All arithmetic is WIDTH bits; no overflow is possible since qout<=modulo after any tick or load.

Test Plan:
- WIDTH=8, reset 1 cycle, en=1, mode=00, prescale=0, modulo=255 -> qout 0,1,..,255,0; tc high only in the cycle qout=0 after 255.
- mode=00, modulo=9, prescale=2 -> qout advances every 3rd cycle, 0..9,0; tc on each 9->0 transition (every 30 cycles).
- mode=10, modulo=3 -> qout 0,1,2,3,2,1,0,1...; dir=1 while descending; tc with qout=2 after 3 and with qout=1 after 0.
- mode=01 from qout=0, modulo=5 -> qout 5 with tc; then load=1, load_val=200 -> qout=5 (clamped), tc=0, pc=0.
- qout=7 with snap=1 and load=1 (load_val=3) in the same cycle -> next cycle snap_q=7, qout=3. Then en=0 for 10 cycles -> qout frozen, tc=0.
- Assert reset mid-count (qout=0x5A, dir=1, pc mid-prescale) -> next cycle qout=RESET_VAL, dir=0, snap_q=0, tc=0. Counting restarts with the full prescale period.
